// File: rtl/timepulse_decoder.sv
// Decodes the timer's ring strobes into one-hot time pulses T01..T12 and counts MCTs.
// Optional ring-protocol checker is compiled in when TPDEC_RINGCHK_EN is defined.
module timepulse_decoder #(
  parameter int TP_COUNT = 12,
  parameter int MCT_W    = 16
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic                EVNSET,
  input  logic                ODDSET_,
  input  logic [4:0]          P,
  input  logic                STOP,
  input  logic                GOJAM_,
  output logic [TP_COUNT-1:0] T,
  output logic                T12DC_,
  output logic                TPSTEP,
  output logic [MCT_W-1:0]    MCT_CNT,
  output logic                RING_ERR
);

  localparam logic [TP_COUNT-1:0] T12_ONLY = {1'b1, {(TP_COUNT-1){1'b0}}};

  logic                r_evnset_q;
  logic [TP_COUNT-1:0] r_t;
  logic                r_t12dc;
  logic                r_tpstep;
  logic [MCT_W-1:0]    r_mct_cnt;

  logic                w_ev_rise;
  logic [TP_COUNT-1:0] w_t_next;
  logic                w_step;
  logic                w_mct_inc;

  assign w_ev_rise = EVNSET & ~r_evnset_q;

  always_comb begin
    w_t_next  = r_t;
    w_step    = 1'b0;
    w_mct_inc = 1'b0;
    if (!GOJAM_) begin
      w_t_next = T12_ONLY;
    end else if (!STOP && w_ev_rise) begin
      w_t_next  = {r_t[TP_COUNT-2:0], r_t[TP_COUNT-1]};
      w_step    = 1'b1;
      w_mct_inc = r_t[TP_COUNT-1];
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_evnset_q <= 1'b0;
      r_t        <= T12_ONLY;
      r_t12dc    <= 1'b0;
      r_tpstep   <= 1'b0;
      r_mct_cnt  <= '0;
    end else begin
      r_evnset_q <= EVNSET;
      r_t        <= w_t_next;
      // T12DC_ tracks the registered T12 bit without a combinational output path
      r_t12dc    <= ~w_t_next[TP_COUNT-1];
      r_tpstep   <= w_step;
      if (w_mct_inc) r_mct_cnt <= r_mct_cnt + 1'b1;
    end
  end

  assign T       = r_t;
  assign T12DC_  = r_t12dc;
  assign TPSTEP  = r_tpstep;
  assign MCT_CNT = r_mct_cnt;

`ifdef TPDEC_RINGCHK_EN
  logic       r_oddset_q;
  logic [4:0] r_p_q;
  logic       r_odd_seen;
  logic       r_ring_err;

  logic       w_od_fall;
  logic       w_p_valid;
  logic       w_p_bad_step;
  logic       w_odd_miss;

  assign w_od_fall    = ~ODDSET_ & r_oddset_q;
  assign w_p_bad_step = (P != r_p_q) && (P != {r_p_q[3:0], ~r_p_q[4]});
  // a coincident odd fall legitimises the even rise in the same cycle
  assign w_odd_miss   = w_ev_rise & ~r_odd_seen & ~w_od_fall;

  always_comb begin
    w_p_valid = 1'b0;
    case (P)
      5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: w_p_valid = 1'b1;
      default: w_p_valid = 1'b0;
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_oddset_q <= 1'b1;
      r_p_q      <= P;
      r_odd_seen <= 1'b1;
      r_ring_err <= 1'b0;
    end else begin
      r_oddset_q <= ODDSET_;
      r_p_q      <= P;
      if (w_ev_rise)      r_odd_seen <= 1'b0;
      else if (w_od_fall) r_odd_seen <= 1'b1;
      if (GOJAM_ && (!w_p_valid || w_p_bad_step || w_odd_miss)) r_ring_err <= 1'b1;
    end
  end

  assign RING_ERR = r_ring_err;
`else
  logic w_unused;
  assign w_unused = ^{P, ODDSET_};
  assign RING_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_timepulse_decoder.sv
// Self-checking bench for timepulse_decoder: directed tables, corner sequences and
// randomized traffic against an index-based reference model.
module tb_timepulse_decoder;

`ifdef TPDEC_RINGCHK_EN
  localparam logic RCHK = 1'b1;
`else
  localparam logic RCHK = 1'b0;
`endif

  logic        SIM_CLK, SIM_RST, EVNSET, ODDSET_, STOP, GOJAM_;
  logic [4:0]  P;
  logic [11:0] T, T_4;
  logic        T12DC_, TPSTEP, RING_ERR, T12DC_4, TPSTEP_4, RING_ERR_4;
  logic [15:0] MCT_CNT;
  logic [3:0]  MCT_CNT_4;

  timepulse_decoder #(.TP_COUNT(12), .MCT_W(16)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .EVNSET(EVNSET), .ODDSET_(ODDSET_), .P(P),
    .STOP(STOP), .GOJAM_(GOJAM_), .T(T), .T12DC_(T12DC_), .TPSTEP(TPSTEP),
    .MCT_CNT(MCT_CNT), .RING_ERR(RING_ERR));

  timepulse_decoder #(.TP_COUNT(12), .MCT_W(4)) dut4 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .EVNSET(EVNSET), .ODDSET_(ODDSET_), .P(P),
    .STOP(STOP), .GOJAM_(GOJAM_), .T(T_4), .T12DC_(T12DC_4), .TPSTEP(TPSTEP_4),
    .MCT_CNT(MCT_CNT_4), .RING_ERR(RING_ERR_4));

  initial begin
    SIM_CLK = 1'b0;
    forever #5 SIM_CLK = ~SIM_CLK;
  end

  int total = 0;
  int bad   = 0;
  int step_cnt = 0;
  bit chk_en = 0;

  logic [4:0] jtab [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

  function automatic int jidx(input logic [4:0] v);
    for (int k = 0; k < 10; k++) if (jtab[k] == v) return k;
    return -1;
  endfunction

  function automatic logic [4:0] succ(input logic [4:0] v);
    int k;
    k = jidx(v);
    return (k < 0) ? jtab[0] : jtab[(k + 1) % 10];
  endfunction

  // reference model: time pulse as an index 0..11 (11 = T12), MCTs as a plain integer
  int         m_t = 11;
  int         m_mct = 0;
  bit         m_step = 0, m_err = 0, m_ev_prev = 0, m_od_prev = 1, m_odd = 1;
  logic [4:0] m_p_prev = 5'b0;

  always @(posedge SIM_CLK) begin
    bit evr, odf;
    int jc, jp;
    if (SIM_RST) begin
      m_t = 11; m_step = 0; m_mct = 0; m_err = 0;
      m_ev_prev = 0; m_od_prev = 1; m_p_prev = P; m_odd = 1;
    end else begin
      evr = EVNSET && !m_ev_prev;
      odf = !ODDSET_ && m_od_prev;
      m_step = 0;
      if (!GOJAM_) m_t = 11;
      else if (!STOP && evr) begin
        m_step = 1;
        if (m_t == 11) begin m_t = 0; m_mct++; end
        else m_t++;
      end
      if (RCHK && GOJAM_) begin
        jc = jidx(P);
        jp = jidx(m_p_prev);
        if (jc < 0) m_err = 1;
        if (P != m_p_prev && !(jp >= 0 && jc == (jp + 1) % 10)) m_err = 1;
        if (evr && !m_odd && !odf) m_err = 1;
      end
      if (evr) m_odd = 0;
      else if (odf) m_odd = 1;
      m_ev_prev = EVNSET; m_od_prev = ODDSET_; m_p_prev = P;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check("model_T", 32'(T), 32'(12'(1) << m_t));
    check("model_T12DC_", 32'(T12DC_), 32'(m_t != 11));
    check("model_TPSTEP", 32'(TPSTEP), 32'(m_step));
    check("model_MCT", 32'(MCT_CNT), 32'(m_mct % 65536));
    check("model_MCT4", 32'(MCT_CNT_4), 32'(m_mct % 16));
    check("model_RING_ERR", 32'(RING_ERR), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge SIM_CLK);
    @(negedge SIM_CLK);
    if (chk_en) compare_model();
    step_cnt += int'(TPSTEP);
  endtask

  task automatic pulse_p(input logic [4:0] pn);
    EVNSET = 1'b1; ODDSET_ = 1'b1; tick(); tick();
    EVNSET = 1'b0; ODDSET_ = 1'b0; P = pn; tick();
    ODDSET_ = 1'b1; tick();
  endtask

  task automatic pulse();
    pulse_p(succ(P));
  endtask

  task automatic do_reset();
    SIM_RST = 1'b1; tick(); tick(); SIM_RST = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  p;
    logic [11:0] exp_t;
    int          exp_mct;
  } pvec_t;

  typedef struct {
    logic        evn, oddn, stop;
    logic [11:0] exp_t;
    logic        exp_step;
  } svec_t;

  pvec_t ptab [12];
  svec_t stab [14];

  initial begin
    for (int i = 0; i < 12; i++) begin
      ptab[i].p = jtab[(i + 1) % 10];
      ptab[i].exp_t = 12'(1) << i;
      ptab[i].exp_mct = 1;
    end
    for (int i = 0; i < 12; i++) begin
      stab[i].evn = (i % 4) < 2;
      stab[i].oddn = (i % 4) != 2;
      stab[i].stop = 1'b1;
      stab[i].exp_t = 12'h040;
      stab[i].exp_step = 1'b0;
    end
    stab[12] = '{evn: 1'b1, oddn: 1'b1, stop: 1'b0, exp_t: 12'h080, exp_step: 1'b1};
    stab[13] = '{evn: 1'b1, oddn: 1'b1, stop: 1'b0, exp_t: 12'h080, exp_step: 1'b0};

    SIM_RST = 1'b1; EVNSET = 1'b0; ODDSET_ = 1'b1; P = 5'b0; STOP = 1'b0; GOJAM_ = 1'b1;
    tick(); tick();
    chk_en = 1;
    tick();
    check("rst_T", 32'(T), 32'h800);
    check("rst_T12DC_", 32'(T12DC_), 32'd0);
    check("rst_TPSTEP", 32'(TPSTEP), 32'd0);
    check("rst_MCT", 32'(MCT_CNT), 32'd0);
    check("rst_RING_ERR", 32'(RING_ERR), 32'd0);
    SIM_RST = 1'b0;

    // clean MCT from reset
    step_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      EVNSET = 1'b1; ODDSET_ = 1'b1; tick();
      check("seq_T", 32'(T), 32'(ptab[i].exp_t));
      check("seq_TPSTEP", 32'(TPSTEP), 32'd1);
      tick();
      EVNSET = 1'b0; ODDSET_ = 1'b0; P = ptab[i].p; tick();
      ODDSET_ = 1'b1; tick();
    end
    check("seq_steps", 32'(step_cnt), 32'd12);
    check("seq_MCT", 32'(MCT_CNT), 32'(ptab[11].exp_mct));
    check("seq_RING_ERR", 32'(RING_ERR), 32'd0);

    // GOJAM_ at T05 with a rise during the low period
    repeat (5) pulse();
    check("gj_at_T05", 32'(T), 32'h010);
    GOJAM_ = 1'b0; tick();
    check("gj_T", 32'(T), 32'h800);
    check("gj_T12DC_", 32'(T12DC_), 32'd0);
    pulse();
    check("gj_hold_T", 32'(T), 32'h800);
    GOJAM_ = 1'b1;
    pulse();
    check("gj_after_T", 32'(T), 32'h001);
    check("gj_after_MCT", 32'(MCT_CNT), 32'd3);

    // STOP at T07 across three rises
    repeat (6) pulse();
    check("stop_at_T07", 32'(T), 32'h040);
    for (int i = 0; i < 14; i++) begin
      EVNSET = stab[i].evn; ODDSET_ = stab[i].oddn; STOP = stab[i].stop;
      tick();
      check("stop_T", 32'(T), 32'(stab[i].exp_t));
      check("stop_TPSTEP", 32'(TPSTEP), 32'(stab[i].exp_step));
    end
    EVNSET = 1'b0; ODDSET_ = 1'b1; tick();

    // randomized traffic with legal P codes
    for (int i = 0; i < 800; i++) begin
      SIM_RST = ($urandom_range(0, 99) == 0);
      EVNSET  = 1'($urandom_range(0, 1));
      ODDSET_ = 1'($urandom_range(0, 1));
      STOP    = ($urandom_range(0, 7) == 0);
      GOJAM_  = !($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) P = succ(P);
      tick();
    end
    SIM_RST = 1'b0; EVNSET = 1'b0; ODDSET_ = 1'b1; STOP = 1'b0; GOJAM_ = 1'b1;

    // 16 full MCTs: 4-bit counter wraps 15 -> 0
    P = 5'b0;
    do_reset();
    for (int i = 1; i <= 192; i++) begin
      pulse();
      if (i == 169) check("wrap_MCT4_15", 32'(MCT_CNT_4), 32'd15);
      if (i == 181) begin
        check("wrap_MCT4_0", 32'(MCT_CNT_4), 32'd0);
        check("wrap_MCT16", 32'(MCT_CNT), 32'd16);
      end
    end

    // P jump 00011 -> 01011
    P = 5'b00011;
    do_reset();
    tick();
    check("viol_pre", 32'(RING_ERR), 32'd0);
    P = 5'b01011; tick();
    check("viol_p", 32'(RING_ERR), 32'(RCHK));
    repeat (3) pulse();
    check("viol_sticky", 32'(RING_ERR), 32'(RCHK));
    do_reset();
    tick();
    check("viol_cleared", 32'(RING_ERR), 32'd0);

    // two even rises without an odd fall
    EVNSET = 1'b1; tick();
    EVNSET = 1'b0; tick();
    EVNSET = 1'b1; tick();
    check("viol_odd", 32'(RING_ERR), 32'(RCHK));
    EVNSET = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
